cache_mem_arbiter: RTL and testbench
====================================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, the line address width.
REQ-002 SHALL have parameter LINE_W, default 128, the cache line width in bits.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port ic_req_valid, input, 1: icache refill (read) request.
REQ-006 SHALL have port ic_req_addr, input, ADDR_W: icache line address.
REQ-007 SHALL have port ic_req_ready, output, 1: icache request accepted this cycle.
REQ-008 SHALL have port ic_resp_valid, output, 1: icache refill data valid.
REQ-009 SHALL have ports dc_req_valid (input, 1), dc_req_rw (input, 1; 1=write), dc_req_addr (input, ADDR_W), dc_req_data (input, LINE_W) and dc_req_ready (output, 1): dcache refill/writeback request.
REQ-010 SHALL have port dc_resp_valid, output, 1: dcache refill data valid.
REQ-011 SHALL have port resp_data, output, LINE_W: refill data shared by both caches, driven directly from mem_resp_data.
REQ-012 SHALL have ports mem_req_valid (output, 1), mem_req_ready (input, 1), mem_req_rw (output, 1), mem_req_addr (output, ADDR_W) and mem_req_data (output, LINE_W): the single main-memory request port.
REQ-013 SHALL have ports mem_resp_valid (input, 1) and mem_resp_data (input, LINE_W): memory read return, one beat per read.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT_RESP.
REQ-016 In IDLE with any request valid, SHALL select an owner, latch the owner's rw, addr and data into internal registers, assert the owner's req_ready for exactly that cycle, and go to ISSUE.
REQ-017 When both requests are valid in IDLE, SHALL grant the cache not granted last; after reset the last-grant register SHALL equal icache, so dcache wins the first tie.
REQ-018 When only one request is valid, SHALL grant it and update last-grant to it.
REQ-019 In ISSUE, SHALL drive mem_req_valid=1 with the latched rw, addr and data, held stable until mem_req_ready=1.
REQ-020 On the ISSUE handshake (mem_req_valid & mem_req_ready), SHALL go to IDLE if rw=1 (write complete, no response), else to WAIT_RESP.
REQ-021 In WAIT_RESP, SHALL route mem_resp_valid to the owner's resp_valid (zero added latency, combinational) and return to IDLE in the same cycle.
REQ-022 SHALL keep ic_resp_valid and dc_resp_valid at 0 outside WAIT_RESP; a mem_resp_valid in IDLE or ISSUE SHALL be ignored.
REQ-023 SHALL never assert ic_req_ready or dc_req_ready outside IDLE, and never both in one cycle.
REQ-024 SHALL not accept a new request in the cycle that returns to IDLE; minimum grant-to-grant spacing is 3 cycles for a write and 4 cycles for a read.
REQ-025 An icache write request is impossible; ic requests SHALL be latched with rw=0.
REQ-026 SHALL drive mem_req_valid=0 outside ISSUE; mem_req_addr, rw and data SHALL always reflect the latched registers.
REQ-027 Request inputs deasserted after grant SHALL not affect the transaction in flight.

Reset
REQ-028 While reset=1 at a clock edge, SHALL enter IDLE, set last-grant to icache and clear the latched rw, addr and data to 0.
REQ-029 After reset, all outputs SHALL be 0: ready, resp_valid, mem_req_valid, busy, and mem_req_addr/data/rw.
REQ-030 Reset asserted mid-transaction (ISSUE or WAIT_RESP) SHALL abort it with no resp_valid pulse; a late mem_resp_valid SHALL be ignored.

Verification
REQ-031 Reset, then dc and ic valid in the same cycle (dc read 0x100, ic 0x200) -> dc_req_ready first, mem read 0x100; after its response, ic granted, mem read 0x200.
REQ-032 dc write at 0x040 with data 0xA5..A5, mem_req_ready held low 5 cycles -> mem_req_valid stable 6 cycles with unchanged addr/data; IDLE after the handshake; no dc_resp_valid.
REQ-033 ic read at 0x010, mem_resp_valid 3 cycles after the handshake with data 0x1234 -> ic_resp_valid for 1 cycle, resp_data=0x1234, dc_resp_valid=0.
REQ-034 Both caches continuously valid for 8 transactions -> grants alternate dc, ic, dc, ...; no two consecutive grants to the same cache.
REQ-035 Reset pulsed during WAIT_RESP, then mem_resp_valid one cycle later -> no resp_valid, busy=0, next request granted normally.
REQ-036 mem_resp_valid injected while IDLE -> no resp_valid output; state unchanged.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and main memory.
// Handshake rule for every req channel: a transfer happens on a rising edge
// where valid and ready are both 1; ready may depend on valid in the same cycle.
// resp_valid pulses carry one beat of refill data and have no back-pressure.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
);
  logic              ic_req_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_req_ready;
  logic              ic_resp_valid;
  logic              dc_req_valid;
  logic              dc_req_rw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [LINE_W-1:0] dc_req_data;
  logic              dc_req_ready;
  logic              dc_resp_valid;
  logic [LINE_W-1:0] resp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_data;
  logic              mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_data;

  // Arbiter side of the bundle.
  modport slave (
    input  ic_req_valid, ic_req_addr, dc_req_valid, dc_req_rw, dc_req_addr,
           dc_req_data, mem_req_ready, mem_resp_valid, mem_resp_data,
    output ic_req_ready, ic_resp_valid, dc_req_ready, dc_resp_valid, resp_data,
           mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
  );

  // Cache/memory side of the bundle.
  modport master (
    output ic_req_valid, ic_req_addr, dc_req_valid, dc_req_rw, dc_req_addr,
           dc_req_data, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  ic_req_ready, ic_resp_valid, dc_req_ready, dc_resp_valid, resp_data,
           mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between the icache and dcache.
// One transaction at a time: grant in IDLE, issue the latched request, and
// for reads wait for the single response beat which is routed to the owner.
// Ties are broken round-robin; one idle cycle follows every completion.
module cache_mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic       clk,
  input  logic       reset,
  cache_mem_arbiter_if.slave bus,
  output logic       busy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t            state;
  logic              last_dc;   // owner of the current/last grant: 1=dcache, 0=icache
  logic              hold;      // blocks granting in the first IDLE cycle after a completion
  logic              lat_rw;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_data;
  logic              mem_valid_q;
  logic              busy_q;
  logic              grant_dc;
  logic              grant_ic;

  // Round-robin selection: dcache wins a tie unless it was granted last.
  always_comb begin
    grant_dc = 1'b0;
    grant_ic = 1'b0;
    if (state == IDLE && !hold) begin
      grant_dc = bus.dc_req_valid && (!bus.ic_req_valid || !last_dc);
      grant_ic = bus.ic_req_valid && !grant_dc;
    end
  end

  // Control FSM with the latched request and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_dc     <= 1'b0;
      hold        <= 1'b0;
      lat_rw      <= 1'b0;
      lat_addr    <= '0;
      lat_data    <= '0;
      mem_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hold <= 1'b0;
          if (grant_dc || grant_ic) begin
            last_dc     <= grant_dc;
            lat_rw      <= grant_dc & bus.dc_req_rw;
            lat_addr    <= grant_dc ? bus.dc_req_addr : bus.ic_req_addr;
            lat_data    <= grant_dc ? bus.dc_req_data : '0;
            mem_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            mem_valid_q <= 1'b0;
            if (lat_rw) begin
              busy_q <= 1'b0;
              hold   <= 1'b1;
              state  <= IDLE;
            end else begin
              state <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (bus.mem_resp_valid) begin
            busy_q <= 1'b0;
            hold   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          mem_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Ready pulses only in the grant cycle; responses route straight to the owner.
  always_comb begin
    bus.ic_req_ready  = grant_ic;
    bus.dc_req_ready  = grant_dc;
    bus.ic_resp_valid = (state == WAIT_RESP) && !last_dc && bus.mem_resp_valid;
    bus.dc_resp_valid = (state == WAIT_RESP) &&  last_dc && bus.mem_resp_valid;
    bus.resp_data     = bus.mem_resp_data;
    bus.mem_req_valid = mem_valid_q;
    bus.mem_req_rw    = lat_rw;
    bus.mem_req_addr  = lat_addr;
    bus.mem_req_data  = lat_data;
    busy              = busy_q;
    dbg_state         = state;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter. Inputs change on the falling edge,
// outputs are checked 1ns later, well away from the rising edge.
module tb_cache_mem_arbiter;
  localparam int AW = 28;
  localparam int LW = 128;

  // Clock / reset
  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_q[$];   // expected grant order, 1=dcache 0=icache

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.ic_req_valid   = 1'b0;
    bus.ic_req_addr    = '0;
    bus.dc_req_valid   = 1'b0;
    bus.dc_req_rw      = 1'b0;
    bus.dc_req_addr    = '0;
    bus.dc_req_data    = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
  endtask

  initial begin
    int grants;
    int last_c;
    logic [LW-1:0] a5;
    a5 = {16{8'hA5}};
    drive_idle();

    // Reset state
    reset = 1'b1;
    cyc(); cyc();
    #1;
    check("rst_ic_ready", bus.ic_req_ready, 0);
    check("rst_dc_ready", bus.dc_req_ready, 0);
    check("rst_ic_resp",  bus.ic_resp_valid, 0);
    check("rst_dc_resp",  bus.dc_resp_valid, 0);
    check("rst_mem_valid", bus.mem_req_valid, 0);
    check("rst_busy",     busy, 0);
    check("rst_addr",     bus.mem_req_addr, 0);
    check("rst_data",     bus.mem_req_data, 0);
    check("rst_rw",       bus.mem_req_rw, 0);
    reset = 1'b0;
    cyc();

    // Simultaneous requests: dcache wins the first tie
    bus.dc_req_valid = 1'b1; bus.dc_req_addr = 'h100;
    bus.ic_req_valid = 1'b1; bus.ic_req_addr = 'h200;
    #1;
    check("tie_dc_ready", bus.dc_req_ready, 1);
    check("tie_ic_ready", bus.ic_req_ready, 0);
    cyc();
    bus.dc_req_valid = 1'b0;
    #1;
    check("tie_mem_valid", bus.mem_req_valid, 1);
    check("tie_mem_addr",  bus.mem_req_addr, 'h100);
    check("tie_mem_rw",    bus.mem_req_rw, 0);
    check("tie_busy",      busy, 1);
    check("tie_state_iss", dbg_state, 1);
    check("tie_ic_wait",   bus.ic_req_ready, 0);
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 'hBEEF;
    #1;
    check("tie_state_wait", dbg_state, 2);
    check("tie_mem_valid0", bus.mem_req_valid, 0);
    check("tie_dc_resp",   bus.dc_resp_valid, 1);
    check("tie_ic_resp0",  bus.ic_resp_valid, 0);
    check("tie_resp_data", bus.resp_data, 'hBEEF);
    cyc();
    bus.mem_resp_valid = 1'b0;
    #1;
    check("tie_cooldown",  bus.ic_req_ready, 0);
    check("tie_busy0",     busy, 0);
    cyc();
    #1;
    check("tie_ic_ready",  bus.ic_req_ready, 1);
    cyc();
    bus.ic_req_valid = 1'b0;
    #1;
    check("tie_ic_addr",   bus.mem_req_addr, 'h200);
    check("tie_ic_valid",  bus.mem_req_valid, 1);
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 'hCAFE;
    #1;
    check("tie_ic_resp",   bus.ic_resp_valid, 1);
    check("tie_dc_resp0",  bus.dc_resp_valid, 0);
    cyc();
    bus.mem_resp_valid = 1'b0;
    cyc();

    // dcache write with memory back-pressure
    bus.dc_req_valid = 1'b1; bus.dc_req_rw = 1'b1;
    bus.dc_req_addr = 'h040; bus.dc_req_data = a5;
    #1;
    check("wr_dc_ready", bus.dc_req_ready, 1);
    cyc();
    bus.dc_req_valid = 1'b0; bus.dc_req_rw = 1'b0;
    bus.dc_req_addr = 'h3FF; bus.dc_req_data = '0;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) bus.mem_req_ready = 1'b1;
      #1;
      check("wr_valid", bus.mem_req_valid, 1);
      check("wr_addr",  bus.mem_req_addr, 'h040);
      check("wr_data",  bus.mem_req_data, a5);
      check("wr_rw",    bus.mem_req_rw, 1);
      cyc();
    end
    bus.mem_req_ready = 1'b0;
    #1;
    check("wr_valid_end", bus.mem_req_valid, 0);
    check("wr_state_idle", dbg_state, 0);
    check("wr_busy0",     busy, 0);
    check("wr_no_resp",   bus.dc_resp_valid, 0);
    cyc();

    // icache read, response three cycles after the handshake
    bus.ic_req_valid = 1'b1; bus.ic_req_addr = 'h010;
    #1;
    check("rd_ic_ready", bus.ic_req_ready, 1);
    cyc();
    bus.ic_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    check("rd_addr", bus.mem_req_addr, 'h010);
    check("rd_rw",   bus.mem_req_rw, 0);
    cyc();
    bus.mem_req_ready = 1'b0;
    #1;
    check("rd_state_wait", dbg_state, 2);
    check("rd_no_resp1", bus.ic_resp_valid, 0);
    cyc();
    #1;
    check("rd_no_resp2", bus.ic_resp_valid, 0);
    cyc();
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 'h1234;
    #1;
    check("rd_ic_resp",  bus.ic_resp_valid, 1);
    check("rd_dc_resp0", bus.dc_resp_valid, 0);
    check("rd_data",     bus.resp_data, 'h1234);
    cyc();
    bus.mem_resp_valid = 1'b0;
    #1;
    check("rd_ic_resp_end", bus.ic_resp_valid, 0);
    check("rd_busy0",       busy, 0);
    cyc();

    // Both caches continuously valid: grants alternate, 4 cycles apart
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 2) == 0);
    bus.dc_req_valid = 1'b1; bus.dc_req_rw = 1'b0; bus.dc_req_addr = 'h500;
    bus.ic_req_valid = 1'b1; bus.ic_req_addr = 'h600;
    bus.mem_req_ready = 1'b1;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 'h77;
    grants = 0;
    last_c = 0;
    for (int c = 0; c < 60 && grants < 8; c++) begin
      #1;
      if (bus.ic_req_ready || bus.dc_req_ready) begin
        check("rr_one_hot", bus.ic_req_ready & bus.dc_req_ready, 0);
        check("rr_order", bus.dc_req_ready, exp_q.pop_front());
        if (grants > 0) check("rr_gap", c - last_c, 4);
        last_c = c;
        grants++;
      end
      cyc();
    end
    check("rr_count", grants, 8);
    bus.dc_req_valid = 1'b0;
    bus.ic_req_valid = 1'b0;
    cyc(); cyc(); cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    #1;
    check("rr_flush_idle", dbg_state, 0);
    cyc();

    // Reset during WAIT_RESP aborts the read; late response ignored
    bus.dc_req_valid = 1'b1; bus.dc_req_addr = 'h300;
    #1;
    check("ab_dc_ready", bus.dc_req_ready, 1);
    cyc();
    bus.dc_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    #1;
    check("ab_state_wait", dbg_state, 2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 'h55;
    #1;
    check("ab_dc_resp0", bus.dc_resp_valid, 0);
    check("ab_ic_resp0", bus.ic_resp_valid, 0);
    check("ab_busy0",    busy, 0);
    check("ab_state",    dbg_state, 0);
    check("ab_addr0",    bus.mem_req_addr, 0);
    cyc();
    bus.mem_resp_valid = 1'b0;
    bus.ic_req_valid = 1'b1; bus.ic_req_addr = 'h400;
    #1;
    check("ab_next_grant", bus.ic_req_ready, 1);
    cyc();
    bus.ic_req_valid = 1'b0;
    #1;
    check("ab_next_addr", bus.mem_req_addr, 'h400);
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b1;
    #1;
    check("ab_next_resp", bus.ic_resp_valid, 1);
    cyc();
    bus.mem_resp_valid = 1'b0;
    cyc();

    // Stray response while IDLE
    for (int k = 0; k < 2; k++) begin
      bus.mem_resp_valid = 1'b1;
      #1;
      check("idle_ic_resp0", bus.ic_resp_valid, 0);
      check("idle_dc_resp0", bus.dc_resp_valid, 0);
      check("idle_state",    dbg_state, 0);
      check("idle_busy0",    busy, 0);
      cyc();
    end
    bus.mem_resp_valid = 1'b0;
    cyc();

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Overall time guard
  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "time limit");
  end
endmodule
